// File: rtl/counter_checker_pkg.sv
// Shared types and defaults for the counter sequence checker.
// Holds the checker state encoding and parameter defaults.
// No logic; imported by counter_checker and its interface users.
package counter_checker_pkg;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } checker_state_e;

  // Default number of consecutive in-sequence samples required to lock.
  localparam int DefaultLockCount = 4;

  // good_run width; LockCount is limited to 1..255.
  localparam int RunWidth = 8;

endpackage

// File: rtl/counter_checker_if.sv
// Bundle between a counter sample source and the counter checker.
// master: drives valid/count/clear_errs, observes locked/error/err_count.
// slave : the checker side, the mirror image of master.
interface counter_checker_if #(
  parameter int Width    = 8,
  parameter int ErrWidth = 16
);
  logic                valid;
  logic [Width-1:0]    count;
  logic                clear_errs;
  logic                locked;
  logic                error;
  logic [ErrWidth-1:0] err_count;

  modport master (
    output valid, count, clear_errs,
    input  locked, error, err_count
  );

  modport slave (
    input  valid, count, clear_errs,
    output locked, error, err_count
  );
endinterface

// File: rtl/counter_checker_sat_counter.sv
// Saturating event counter with synchronous clear.
// Latency: one cycle from inc/clear to count.
// Backpressure: none; clear together with inc yields 1 so the new event is kept.
// Ports: clk, reset (sync, active-low), inc, clear, count[Width-1:0].
module sat_counter #(
  parameter int Width = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clear,
  output logic [Width-1:0] count
);

  localparam logic [Width-1:0] MaxVal = '1;

  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= inc ? Width'(1) : '0;
    end else if (inc && (count != MaxVal)) begin
      count <= count + Width'(1);
    end
  end

endmodule

// File: rtl/counter_checker.sv
// Monitors a free-running up-counter, locks on the +1 sequence, flags breaks.
// Latency: locked/error/err_count reflect a sample one cycle after its valid cycle.
// Backpressure: none; every valid sample is consumed, valid=0 cycles are ignored.
// Ports: clk, reset (sync, active-low), bus (counter_checker_if.slave):
//   valid/count/clear_errs in, locked/error/err_count out.
// Optional: define COUNTER_CHECKER_RESYNC_ZERO_EN to accept a sample of 0 while
//   locked as an upstream counter restart instead of a sequence break.
module counter_checker
  import counter_checker_pkg::*;
#(
  parameter int Width     = 8,
  parameter int LockCount = DefaultLockCount,
  parameter int ErrWidth  = 16
) (
  input  logic               clk,
  input  logic               reset,
  counter_checker_if.slave   bus
);

  localparam logic [RunWidth-1:0] LockTarget = RunWidth'(LockCount);

  checker_state_e      state;
  logic [Width-1:0]    expected;
  logic [RunWidth-1:0] good_run;
  logic                locked_q;
  logic                error_q;

  logic                match;
  logic                resync_zero;
  logic                break_hit;
  logic [RunWidth-1:0] good_run_inc;

  assign match        = (bus.count == expected);
  assign good_run_inc = good_run + RunWidth'(1);

`ifdef COUNTER_CHECKER_RESYNC_ZERO_EN
  // A zero that does not match can only mean expected != 0: treat as restart.
  assign resync_zero = (bus.count == '0);
`else
  assign resync_zero = 1'b0;
`endif

  // Sequence break while locked: drives both the error pulse and the tally.
  assign break_hit = reset && bus.valid && (state == LOCKED) && !match && !resync_zero;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= HUNT;
      expected <= '0;
      good_run <= '0;
      locked_q <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      error_q <= 1'b0;
      if (bus.valid) begin
        case (state)
          HUNT: begin
            expected <= bus.count + Width'(1);
            good_run <= RunWidth'(1);
            if (LockCount == 1) begin
              state    <= LOCKED;
              locked_q <= 1'b1;
            end else begin
              state <= ACQUIRE;
            end
          end
          ACQUIRE: begin
            if (match) begin
              expected <= expected + Width'(1);
              good_run <= good_run_inc;
              // >= also covers LockCount==1 re-acquiring after a break.
              if (good_run_inc >= LockTarget) begin
                state    <= LOCKED;
                locked_q <= 1'b1;
              end
            end else begin
              expected <= bus.count + Width'(1);
              good_run <= RunWidth'(1);
            end
          end
          LOCKED: begin
            if (match) begin
              expected <= expected + Width'(1);
            end else if (resync_zero) begin
              expected <= Width'(1);
            end else begin
              error_q  <= 1'b1;
              locked_q <= 1'b0;
              state    <= ACQUIRE;
              good_run <= RunWidth'(1);
              expected <= bus.count + Width'(1);
            end
          end
          default: begin
            state    <= HUNT;
            locked_q <= 1'b0;
          end
        endcase
      end
    end
  end

  sat_counter #(
    .Width(ErrWidth)
  ) u_err_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (break_hit),
    .clear (bus.clear_errs),
    .count (bus.err_count)
  );

  assign bus.locked = locked_q;
  assign bus.error  = error_q;

endmodule

// File: tb/tb_counter_checker.sv
// Directed self-checking bench for counter_checker (Width=8, LockCount=4, ErrWidth=2).
// Inputs change on the falling edge; outputs are checked 1ns after the rising edge.
// Expected values are hand-derived per step.
module tb_counter_checker;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  counter_checker_if #(.Width(8), .ErrWidth(2)) bus ();

  counter_checker #(
    .Width     (8),
    .LockCount (4),
    .ErrWidth  (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Present one input vector for one rising edge, then step 1ns past it.
  task automatic drive(input logic v, input logic [7:0] c, input logic clr);
    @(negedge clk);
    bus.valid      = v;
    bus.count      = c;
    bus.clear_errs = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic lk, input logic er, input logic [1:0] ec);
    chk({tag, ".locked"},    32'(bus.locked),    32'(lk));
    chk({tag, ".error"},     32'(bus.error),     32'(er));
    chk({tag, ".err_count"}, 32'(bus.err_count), 32'(ec));
  endtask

  initial begin
    reset          = 1'b0;
    bus.valid      = 1'b0;
    bus.count      = '0;
    bus.clear_errs = 1'b0;

    // Reset state
    drive(1'b0, 8'd0, 1'b0);
    drive(1'b1, 8'd99, 1'b0);
    expect_out("reset", 1'b0, 1'b0, 2'd0);
    @(negedge clk);
    reset = 1'b1;

    // Acquire on 10..13: lock the cycle after 13
    drive(1'b1, 8'd10, 1'b0); expect_out("acq10", 1'b0, 1'b0, 2'd0);
    drive(1'b1, 8'd11, 1'b0); expect_out("acq11", 1'b0, 1'b0, 2'd0);
    drive(1'b1, 8'd12, 1'b0); expect_out("acq12", 1'b0, 1'b0, 2'd0);
    drive(1'b1, 8'd13, 1'b0); expect_out("acq13", 1'b1, 1'b0, 2'd0);

    // Run on to expected=20, with an idle cycle in between
    drive(1'b0, 8'd77, 1'b0); expect_out("idle", 1'b1, 1'b0, 2'd0);
    for (int i = 14; i < 20; i++) begin
      drive(1'b1, 8'(i), 1'b0);
      expect_out("run", 1'b1, 1'b0, 2'd0);
    end

    // Break: 25 instead of 20
    drive(1'b1, 8'd25, 1'b0); expect_out("brk25", 1'b0, 1'b1, 2'd1);
    drive(1'b0, 8'd0, 1'b0);  expect_out("brk25_pulse", 1'b0, 1'b0, 2'd1);
    drive(1'b1, 8'd26, 1'b0); expect_out("re26", 1'b0, 1'b0, 2'd1);
    drive(1'b1, 8'd27, 1'b0); expect_out("re27", 1'b0, 1'b0, 2'd1);
    drive(1'b1, 8'd28, 1'b0); expect_out("re28", 1'b1, 1'b0, 2'd1);

    // Break to 250, relock on 253, then wrap 254,255,0,1
    drive(1'b1, 8'd250, 1'b0); expect_out("brk250", 1'b0, 1'b1, 2'd2);
    drive(1'b1, 8'd251, 1'b0); expect_out("re251", 1'b0, 1'b0, 2'd2);
    drive(1'b1, 8'd252, 1'b0); expect_out("re252", 1'b0, 1'b0, 2'd2);
    drive(1'b1, 8'd253, 1'b0); expect_out("re253", 1'b1, 1'b0, 2'd2);
    drive(1'b1, 8'd254, 1'b0); expect_out("wrap254", 1'b1, 1'b0, 2'd2);
    drive(1'b1, 8'd255, 1'b0); expect_out("wrap255", 1'b1, 1'b0, 2'd2);
    drive(1'b1, 8'd0, 1'b0);   expect_out("wrap0", 1'b1, 1'b0, 2'd2);
    drive(1'b1, 8'd1, 1'b0);   expect_out("wrap1", 1'b1, 1'b0, 2'd2);

    // Stalled counter (repeat of 1) is a break
    drive(1'b1, 8'd1, 1'b0); expect_out("stall", 1'b0, 1'b1, 2'd3);
    drive(1'b1, 8'd2, 1'b0);
    drive(1'b1, 8'd3, 1'b0);
    drive(1'b1, 8'd4, 1'b0); expect_out("re4", 1'b1, 1'b0, 2'd3);

    // Breaks 4 and 5: tally saturates at 3
    drive(1'b1, 8'd9, 1'b0);  expect_out("sat4", 1'b0, 1'b1, 2'd3);
    drive(1'b1, 8'd10, 1'b0);
    drive(1'b1, 8'd11, 1'b0);
    drive(1'b1, 8'd12, 1'b0); expect_out("re12", 1'b1, 1'b0, 2'd3);
    drive(1'b1, 8'd40, 1'b0); expect_out("sat5", 1'b0, 1'b1, 2'd3);

    // clear_errs coincident with a break gives 1; clear alone gives 0
    drive(1'b1, 8'd41, 1'b0);
    drive(1'b1, 8'd42, 1'b0);
    drive(1'b1, 8'd43, 1'b0); expect_out("re43", 1'b1, 1'b0, 2'd3);
    drive(1'b1, 8'd100, 1'b1); expect_out("clr_brk", 1'b0, 1'b1, 2'd1);
    drive(1'b0, 8'd0, 1'b1);   expect_out("clr_only", 1'b0, 1'b0, 2'd0);

    // Lock with expected=50, then present 0
    drive(1'b1, 8'd46, 1'b0); expect_out("acq46", 1'b0, 1'b0, 2'd0);
    drive(1'b1, 8'd47, 1'b0);
    drive(1'b1, 8'd48, 1'b0);
    drive(1'b1, 8'd49, 1'b0); expect_out("re49", 1'b1, 1'b0, 2'd0);
    drive(1'b1, 8'd0, 1'b0);
`ifdef COUNTER_CHECKER_RESYNC_ZERO_EN
    expect_out("zero_resync", 1'b1, 1'b0, 2'd0);
    drive(1'b1, 8'd1, 1'b0); expect_out("resync1", 1'b1, 1'b0, 2'd0);
`else
    expect_out("zero_break", 1'b0, 1'b1, 2'd1);
    drive(1'b1, 8'd1, 1'b0); expect_out("after0", 1'b0, 1'b0, 2'd1);
`endif
    drive(1'b1, 8'd2, 1'b0);
    drive(1'b1, 8'd3, 1'b0);
    drive(1'b1, 8'd4, 1'b0);
    chk("prereset.locked", 32'(bus.locked), 32'd1);

    // Reset mid-lock overrides a valid, mismatching sample
    @(negedge clk);
    reset = 1'b0;
    drive(1'b1, 8'd77, 1'b0); expect_out("midreset", 1'b0, 1'b0, 2'd0);
    @(negedge clk);
    reset = 1'b1;
    drive(1'b1, 8'd200, 1'b0); expect_out("hunt200", 1'b0, 1'b0, 2'd0);
    drive(1'b1, 8'd201, 1'b0); expect_out("hunt201", 1'b0, 1'b0, 2'd0);
    drive(1'b1, 8'd202, 1'b0); expect_out("hunt202", 1'b0, 1'b0, 2'd0);
    drive(1'b1, 8'd203, 1'b0); expect_out("hunt203", 1'b1, 1'b0, 2'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
